// File: rtl/uart_word_rx.sv
// UART 8N1 receiver that packs four bytes (little-endian) into a 32-bit valid/ready word.
// Define UART_PARITY_EN for 8E1 frames with a PARITY state and a sticky parity_err output.
//
// state  | meaning
// IDLE   | waiting for a falling edge on synchronised rx; timeout runs here
// START  | half-bit wait, then confirm the start bit is still low
// DATA   | eight LSB-first data samples, one per bit period
// PARITY | even-parity sample (UART_PARITY_EN only)
// STOP   | stop-bit sample; accept byte or flag a framing error
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        word_ready,
    input  logic        clr_status,
    output logic [31:0] word_data,
    output logic        word_valid,
    output logic [1:0]  byte_cnt,
    output logic        rx_busy,
    output logic        frame_err,
    output logic        overrun
`ifdef UART_PARITY_EN
    ,
    output logic        parity_err
`endif
);

    localparam int BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);

    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TO_CYCLES);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_nxt;

    logic              rx_meta, rx_sync, rx_prev;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic [TO_W-1:0]   to_cnt;
    logic [31:0]       asm_word;
    logic              word_pending;

    logic start_edge, baud_done, stop_sample, byte_ok, frame_bad;
    logic to_run, timeout_hit, load_ok;

`ifdef UART_PARITY_EN
    logic par_bad;
    logic par_sample;
`endif

    // Synchroniser presets high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge  = rx_prev & ~rx_sync;
    assign baud_done   = (baud_cnt <= BAUD_ONE);
    assign stop_sample = (state == STOP) && baud_done;
    assign frame_bad   = stop_sample && !rx_sync;
`ifdef UART_PARITY_EN
    assign par_sample  = (state == PARITY) && baud_done;
    assign byte_ok     = stop_sample && rx_sync && !par_bad;
`else
    assign byte_ok     = stop_sample && rx_sync;
`endif
    assign to_run      = (state == IDLE) && (byte_cnt != 2'd0);
    assign timeout_hit = to_run && !start_edge && (to_cnt <= TO_ONE);
    assign load_ok     = word_pending && (!word_valid || word_ready);
    assign rx_busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_edge) state_nxt = START;
            START:  if (baud_done) state_nxt = rx_sync ? IDLE : DATA;
`ifdef UART_PARITY_EN
            DATA:   if (baud_done && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY: if (baud_done) state_nxt = STOP;
`else
            DATA:   if (baud_done && bit_cnt == 3'd7) state_nxt = STOP;
`endif
            STOP:   if (baud_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == IDLE) begin
                if (start_edge) baud_cnt <= BAUD_HALF;
            end else if (baud_done) begin
                baud_cnt <= BAUD_FULL;
            end else begin
                baud_cnt <= baud_cnt - BAUD_ONE;
            end
            if (state == DATA && baud_done) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
                bit_cnt   <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == IDLE && start_edge) par_bad <= 1'b0;
            else if (par_sample)             par_bad <= ^{shift_reg, rx_sync};
            if (par_sample && (^{shift_reg, rx_sync})) parity_err <= 1'b1;
            else if (clr_status)                       parity_err <= 1'b0;
        end
    end
`endif

    // Partial-word assembly and idle timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt     <= 2'd0;
            asm_word     <= '0;
            word_pending <= 1'b0;
            to_cnt       <= '0;
        end else begin
            word_pending <= byte_ok && (byte_cnt == 2'd3);
            if (byte_ok) begin
                asm_word[{byte_cnt, 3'b000} +: 8] <= shift_reg;
                byte_cnt <= byte_cnt + 2'd1;
            end else if (timeout_hit) begin
                byte_cnt <= 2'd0;
            end
            if (state == IDLE && start_edge) to_cnt <= TO_LOAD;
            else if (to_run)                 to_cnt <= (to_cnt <= TO_ONE) ? '0 : to_cnt - TO_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_data  <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load_ok) begin
                word_data  <= asm_word;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (word_pending && !load_ok) overrun <= 1'b1;
            else if (clr_status)          overrun <= 1'b0;
            if (frame_bad)       frame_err <= 1'b1;
            else if (clr_status) frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: table-driven words plus glitch, framing, overrun,
// timeout and mid-frame reset sequences.
module tb_uart_word_rx;
    localparam int CPB = 87;
    localparam int TOB = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        word_ready = 1'b0;
    logic        clr_status = 1'b0;
    logic [31:0] word_data;
    logic        word_valid;
    logic [1:0]  byte_cnt;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;
`ifdef UART_PARITY_EN
    logic        parity_err;
`endif

    uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .word_ready (word_ready),
        .clr_status (clr_status),
        .word_data  (word_data),
        .word_valid (word_valid),
        .byte_cnt   (byte_cnt),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef UART_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int valid_cycles = 0;
    int xfers = 0;
    logic [31:0] last_xfer = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (word_valid) valid_cycles <= valid_cycles + 1;
            if (word_valid && word_ready) begin
                xfers     <= xfers + 1;
                last_xfer <= word_data;
            end
        end
    end

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[3];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CPB);
        end
`ifdef UART_PARITY_EN
        rx = ^b;
        step(CPB);
`endif
        rx = stop_bit;
        step(CPB);
        rx = 1'b1;
        step(4);
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input string tag);
        logic [7:0] bs[4];
        bs = '{b0, b1, b2, b3};
        for (int k = 0; k < 4; k++) begin
            send_byte(bs[k], 1'b1);
            chk({tag, "_byte_cnt"}, {30'd0, byte_cnt}, 32'((k + 1) % 4));
        end
    endtask

    initial begin
        int v0, x0;
        vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        vecs[1] = '{8'h00, 8'hFF, 8'h80, 8'h01, 32'h0180FF00};
        vecs[2] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};

        step(3);
        chk("rst_word_data", word_data, 32'h0);
        chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_byte_cnt", {30'd0, byte_cnt}, 32'd0);
        chk("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
        rst_n = 1'b1;
        step(5);
        chk("idle_after_rst", {31'd0, rx_busy}, 32'd0);
        word_ready = 1'b1;

        for (int v = 0; v < 3; v++) begin
            v0 = valid_cycles;
            x0 = xfers;
            send4(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_valid_cycles", v), 32'(valid_cycles - v0), 32'd1);
            chk($sformatf("vec%0d_xfers", v), 32'(xfers - x0), 32'd1);
            chk($sformatf("vec%0d_data", v), last_xfer, vecs[v].exp);
            chk($sformatf("vec%0d_valid_low", v), {31'd0, word_valid}, 32'd0);
            chk($sformatf("vec%0d_flags", v), {30'd0, frame_err, overrun}, 32'd0);
        end

        // Short low pulse: start bit rejected at mid-bit
        v0 = valid_cycles;
        rx = 1'b0;
        step(10);
        chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
        step(CPB / 2 - 2 - 10);
        rx = 1'b1;
        step(2 * CPB);
        chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
        chk("glitch_byte_cnt", {30'd0, byte_cnt}, 32'd0);
        chk("glitch_valid", 32'(valid_cycles - v0), 32'd0);
        chk("glitch_flags", {30'd0, frame_err, overrun}, 32'd0);

        // Framing error
        send_byte(8'hA5, 1'b0);
        step(CPB);
        chk("ferr_set", {31'd0, frame_err}, 32'd1);
        chk("ferr_byte_cnt", {30'd0, byte_cnt}, 32'd0);
        chk("ferr_overrun", {31'd0, overrun}, 32'd0);
        clr_status = 1'b1;
        step(1);
        clr_status = 1'b0;
        step(1);
        chk("ferr_clr", {31'd0, frame_err}, 32'd0);

        // Overrun with consumer stalled
        word_ready = 1'b0;
        x0 = xfers;
        send4(8'hEF, 8'hBE, 8'hAD, 8'hDE, "ovr_w0");
        chk("ovr_first_valid", {31'd0, word_valid}, 32'd1);
        chk("ovr_first_data", word_data, 32'hDEADBEEF);
        chk("ovr_first_flag", {31'd0, overrun}, 32'd0);
        send4(8'h04, 8'h03, 8'h02, 8'h01, "ovr_w1");
        chk("ovr_hold_data", word_data, 32'hDEADBEEF);
        chk("ovr_hold_valid", {31'd0, word_valid}, 32'd1);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        chk("ovr_no_xfer", 32'(xfers - x0), 32'd0);
        word_ready = 1'b1;
        step(1);
        chk("ovr_one_xfer", 32'(xfers - x0), 32'd1);
        chk("ovr_xfer_data", last_xfer, 32'hDEADBEEF);
        chk("ovr_valid_drop", {31'd0, word_valid}, 32'd0);
        step(3);
        chk("ovr_still_one", 32'(xfers - x0), 32'd1);
        clr_status = 1'b1;
        step(1);
        clr_status = 1'b0;
        step(1);
        chk("ovr_clr", {31'd0, overrun}, 32'd0);

        // Partial-word timeout
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        chk("to_partial", {30'd0, byte_cnt}, 32'd2);
        step(38 * CPB);
        chk("to_before", {30'd0, byte_cnt}, 32'd2);
        step(3 * CPB);
        chk("to_after", {30'd0, byte_cnt}, 32'd0);
        chk("to_flags", {30'd0, frame_err, overrun}, 32'd0);
        x0 = xfers;
        send4(8'h01, 8'h02, 8'h03, 8'h04, "to_word");
        chk("to_word_xfer", 32'(xfers - x0), 32'd1);
        chk("to_word_data", last_xfer, 32'h04030201);

        // Asynchronous reset in the middle of byte 2's data bits
        send_byte(8'h0D, 1'b1);
        chk("rstmid_cnt", {30'd0, byte_cnt}, 32'd1);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = (i == 1);
            step(CPB);
        end
        chk("rstmid_busy", {31'd0, rx_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_word_data", word_data, 32'h0);
        chk("rstmid_outs", {26'd0, word_valid, byte_cnt, rx_busy, frame_err, overrun}, 32'd0);
        rx = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(2 * CPB);
        x0 = xfers;
        send4(8'h0D, 8'hF0, 8'hFE, 8'hCA, "post_rst");
        chk("post_rst_xfer", 32'(xfers - x0), 32'd1);
        chk("post_rst_data", last_xfer, 32'hCAFEF00D);
        chk("post_rst_flags", {30'd0, frame_err, overrun}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
